mem_bus_arbiter: RTL

- Shares the single memory port between two requesters: the instruction-fetch unit and the LSU.
- Handshake on every interface: req/gnt for the address phase, rvalid for the response phase.
- Enforces stable requests while waiting for a grant and tracks outstanding transactions in order, so each response returns to the requester that issued it.
- Sits between the IF/LSU stages and the memory interface, so the controller FSM sees independent instruction and data channels.

---
 rtl/mem_bus_arbiter_pkg.sv | 20 ++
 rtl/mem_bus_arbiter_owner_fifo.sv | 52 +++++
 rtl/mem_bus_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
// Owner ids travel through the response-ordering FIFO.
package mem_bus_arbiter_pkg;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } arb_owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HOLD_INSTR,
        ARB_HOLD_DATA
    } arb_state_e;

    function automatic arb_state_e hold_state(input arb_owner_e o);
        return (o == OWNER_DATA) ? ARB_HOLD_DATA : ARB_HOLD_INSTR;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_owner_fifo.sv
// In-order FIFO of transaction owners awaiting a memory response.
// Simultaneous push and pop leave the count unchanged.
module mem_arb_owner_fifo
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  arb_owner_e    push_owner,
    input  logic          pop,
    output arb_owner_e    head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    arb_owner_e    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_owner;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory port arbiter (fetch vs LSU) with in-order
// response routing and a starvation guard for instruction fetch.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_req_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,
    output logic                instr_err_o,
    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                data_err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_err_i,
    output logic                busy_o,
    output logic                proto_err_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e    state_q, state_d;
    arb_owner_e    owner;
    arb_owner_e    head;
    logic          req;
    logic          is_data;
    logic          granted;
    logic          can_issue;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic [CW-1:0] fifo_count;
    logic [SW-1:0] starve_q;
    logic          proto_q;

    // can_issue depends only on registered count, never on mem_rvalid_i
    assign can_issue = !fifo_full;

    always_comb begin
        state_d = state_q;
        owner   = OWNER_DATA;
        req     = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (can_issue && (instr_req_i || data_req_i)) begin
                    req   = 1'b1;
                    owner = (!data_req_i || starve_q == SW'(STARVE_LIMIT))
                          ? OWNER_INSTR : OWNER_DATA;
                    if (!mem_gnt_i) state_d = hold_state(owner);
                end
            end
            ARB_HOLD_INSTR: begin
                req   = 1'b1;
                owner = OWNER_INSTR;
                if (mem_gnt_i) state_d = ARB_IDLE;
            end
            ARB_HOLD_DATA: begin
                req   = 1'b1;
                owner = OWNER_DATA;
                if (mem_gnt_i) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ARB_IDLE;
        else     state_q <= state_d;
    end

    assign is_data     = (owner == OWNER_DATA);
    assign granted     = req && mem_gnt_i;
    assign instr_gnt_o = granted && !is_data;
    assign data_gnt_o  = granted && is_data;

    assign mem_req_o   = req;
    assign mem_we_o    = req && is_data && data_we_i;
    assign mem_be_o    = !req ? '0 : (is_data ? data_be_i : '1);
    assign mem_addr_o  = !req ? '0 : (is_data ? data_addr_i : instr_addr_i);
    assign mem_wdata_o = (req && is_data) ? data_wdata_i : '0;

    assign pop = mem_rvalid_i && !fifo_empty;

    mem_arb_owner_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (granted),
        .push_owner(owner),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign instr_rvalid_o = pop && (head == OWNER_INSTR);
    assign data_rvalid_o  = pop && (head == OWNER_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
    assign instr_err_o    = instr_rvalid_o && mem_err_i;
    assign data_err_o     = data_rvalid_o && mem_err_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            proto_q  <= 1'b0;
        end else begin
            if (!instr_req_i || instr_gnt_o)
                starve_q <= '0;
            else if (data_gnt_o && starve_q != SW'(STARVE_LIMIT))
                starve_q <= starve_q + 1'b1;
            if (mem_rvalid_i && fifo_empty) proto_q <= 1'b1;
        end
    end

    assign proto_err_o = proto_q;
    assign busy_o      = (fifo_count != '0) || req;

endmodule
